// File: rtl/program_loader.sv
// Boot loader: length-prefixed LE byte stream -> imem words; holds core in reset until done.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte gating core release.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, PAYLOAD, FIN, RUN, ERR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t state, state_n;

  logic        armed;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  bcnt;
  logic [23:0] word;
  logic        accept;
  logic [15:0] len_full;
  logic        bad_len;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len_lo};
  assign bad_len   = (len_full == 16'd0) || (len_full > 16'(DEPTH));
  assign last_word = (16'(words_loaded) + 16'd1) == len;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] cks;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cks <= '0;
    end else if (state == LEN_HI && accept) begin
      cks <= '0;
    end else if (state == PAYLOAD && accept) begin
      cks <= cks ^ rx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LEN_LO;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LEN_LO:  if (accept) state_n = LEN_HI;
      LEN_HI:  if (accept) state_n = bad_len ? ERR : PAYLOAD;
      PAYLOAD: if (accept && bcnt == 2'd3 && last_word) state_n = FIN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      FIN:     state_n = CHECK;
      CHECK:   if (accept) state_n = (cks == rx_data) ? RUN : ERR;
`else
      FIN:     state_n = RUN;
`endif
      RUN:     if (restart) state_n = LEN_LO;
      ERR:     if (restart) state_n = LEN_LO;
      default: state_n = LEN_LO;
    endcase
  end

  // armed keeps rx_ready low while reset is asserted and for the reset cycle itself
  always_comb begin
    rx_ready = 1'b0;
    if (armed) begin
      unique case (state)
        LEN_LO, LEN_HI, PAYLOAD: rx_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK:                   rx_ready = 1'b1;
`endif
        default:                 rx_ready = 1'b0;
      endcase
    end
  end

  assign core_reset = (state != RUN);
  assign done       = (state == RUN);
  assign error      = (state == ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      len_lo       <= '0;
      len          <= '0;
      bcnt         <= '0;
      word         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      if (state == LEN_LO && accept) len_lo <= rx_data;
      if (state == LEN_HI && accept) begin
        len          <= len_full;
        bcnt         <= '0;
        words_loaded <= '0;
      end
      if (state == PAYLOAD && accept) begin
        bcnt <= bcnt + 2'd1;
        word <= {rx_data, word[23:8]};
        if (bcnt == 2'd3) begin
          imem_we      <= 1'b1;
          imem_addr    <= words_loaded[ADDR_W-1:0];
          imem_wdata   <= {rx_data, word};
          words_loaded <= words_loaded + 1'b1;
        end
      end
      if ((state == RUN || state == ERR) && restart) words_loaded <= '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of images plus stall/reset/limit sequences.
// Checksum-specific checks are compiled when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  logic        clk = 0;
  logic        reset = 1;
  logic        restart = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  program_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] img [256];
  logic [7:0]  xacc;
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; rx_valid = 0; restart = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: rx_ready stuck at 0, required 1");
    end
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_len(input logic [15:0] len);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic send_words(input int n, input int gap);
    xacc = 0;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(img[i][8*b +: 8]);
        xacc ^= img[i][8*b +: 8];
        repeat (gap) @(negedge clk);
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(xacc);
`endif
  endtask

  task automatic wait_end();
    int t = 0;
    while (!done && !error && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("end_timeout", {31'd0, done | error}, 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [31:0] w0, w1, w2;
    bit          err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'd1,    1, 32'h00A00513, 32'h0,        32'h0,        1'b0};
    vecs[1] = '{16'd2,    2, 32'hDEADBEEF, 32'h12345678, 32'h0,        1'b0};
    vecs[2] = '{16'd3,    3, 32'h00000000, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[3] = '{16'd0,    0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[4] = '{16'd257,  0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[5] = '{16'h8000, 0, 32'h0,        32'h0,        32'h0,        1'b1};

    // reset values while reset held
    #1;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_words", {23'd0, words_loaded}, 32'd0);
    do_reset();
    chk("rst_ready_low", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    chk("rst_ready_rise", {31'd0, rx_ready}, 32'd1);

    // hand sequence: single addi word, exact release timing
    img[0] = 32'h00A00513;
    send_len(16'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    chk("t1_we", {31'd0, imem_we}, 32'd1);
    chk("t1_addr", {24'd0, imem_addr}, 32'd0);
    chk("t1_wdata", imem_wdata, 32'h00A00513);
    chk("t1_ready_off", {31'd0, rx_ready}, 32'd0);
    chk("t1_core_held", {31'd0, core_reset}, 32'd1);
    chk("t1_words", {23'd0, words_loaded}, 32'd1);
    @(negedge clk);
    chk("t1_we_pulse", {31'd0, imem_we}, 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk("t1_wait_cks", {31'd0, core_reset}, 32'd1);
    send_byte(8'hB6);
`endif
    chk("t1_core_rel", {31'd0, core_reset}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_nwrites", wr_addr.size(), 32'd1);

    // restart from RUN
    restart = 1;
    @(negedge clk);
    restart = 0;
    chk("rs_done", {31'd0, done}, 32'd0);
    chk("rs_core", {31'd0, core_reset}, 32'd1);
    chk("rs_words", {23'd0, words_loaded}, 32'd0);
    chk("rs_ready", {31'd0, rx_ready}, 32'd1);

    // table of images
    for (int v = 0; v < 6; v++) begin
      do_reset();
      img[0] = vecs[v].w0; img[1] = vecs[v].w1; img[2] = vecs[v].w2;
      send_len(vecs[v].len);
      if (!vecs[v].err) send_words(vecs[v].nw, 0);
      wait_end();
      chk($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vecs[v].err});
      chk($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, !vecs[v].err});
      chk($sformatf("v%0d_core", v), {31'd0, core_reset}, {31'd0, vecs[v].err});
      chk($sformatf("v%0d_ready", v), {31'd0, rx_ready}, 32'd0);
      chk($sformatf("v%0d_words", v), {23'd0, words_loaded}, vecs[v].nw);
      chk($sformatf("v%0d_nwr", v), wr_addr.size(), vecs[v].nw);
      for (int i = 0; i < vecs[v].nw && i < wr_addr.size(); i++) begin
        chk($sformatf("v%0d_a%0d", v, i), {24'd0, wr_addr[i]}, i);
        chk($sformatf("v%0d_d%0d", v, i), wr_data[i], img[i]);
      end
      if (vecs[v].err) begin
        restart = 1;
        @(negedge clk);
        restart = 0;
        chk($sformatf("v%0d_clr", v), {31'd0, error}, 32'd0);
        chk($sformatf("v%0d_rdy", v), {31'd0, rx_ready}, 32'd1);
      end
    end

    // stalled stream, valid toggling every other cycle
    do_reset();
    img[0] = 32'h11223344; img[1] = 32'hA5A55A5A; img[2] = 32'h0BADF00D;
    send_len(16'd3);
    send_words(3, 1);
    wait_end();
    chk("st_nwr", wr_addr.size(), 32'd3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      chk($sformatf("st_a%0d", i), {24'd0, wr_addr[i]}, i);
      chk($sformatf("st_d%0d", i), wr_data[i], img[i]);
    end
    chk("st_ready", {31'd0, rx_ready}, 32'd0);
    chk("st_done", {31'd0, done}, 32'd1);

    // full depth image
    do_reset();
    for (int i = 0; i < 256; i++)
      img[i] = {i[7:0] ^ 8'h5A, i[7:0], 8'hC3, ~i[7:0]};
    send_len(16'd256);
    send_words(256, 0);
    wait_end();
    chk("full_nwr", wr_addr.size(), 32'd256);
    chk("full_last_a", {24'd0, wr_addr[wr_addr.size()-1]}, 32'd255);
    chk("full_last_d", wr_data[wr_data.size()-1], img[255]);
    chk("full_words", {23'd0, words_loaded}, 32'd256);
    chk("full_done", {31'd0, done}, 32'd1);

    // reset after 2 payload bytes of word 1
    do_reset();
    img[0] = 32'h01020304; img[1] = 32'h05060708;
    send_len(16'd2);
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8]);
    send_byte(8'h08); send_byte(8'h07);
    reset = 1;
    #1;
    chk("mid_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_words", {23'd0, words_loaded}, 32'd0);
    chk("mid_core", {31'd0, core_reset}, 32'd1);
    chk("mid_wdata", imem_wdata, 32'd0);
    wr_addr.delete(); wr_data.delete();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("mid_nowr", wr_addr.size(), 32'd0);
    img[0] = 32'hCAFEF00D;
    send_len(16'd1);
    send_words(1, 0);
    wait_end();
    chk("mid_nwr", wr_addr.size(), 32'd1);
    chk("mid_a0", {24'd0, wr_addr[0]}, 32'd0);
    chk("mid_d0", wr_data[0], 32'hCAFEF00D);
    chk("mid_done", {31'd0, done}, 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // wrong checksum: word written, core held
    do_reset();
    send_len(16'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    send_byte(8'hB7);
    chk("ck_error", {31'd0, error}, 32'd1);
    chk("ck_core", {31'd0, core_reset}, 32'd1);
    chk("ck_done", {31'd0, done}, 32'd0);
    chk("ck_nwr", wr_addr.size(), 32'd1);
    chk("ck_d0", wr_data[0], 32'h00A00513);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
